fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch sequencer for the IF→ID front end of the core. Owns the next-fetch PC, issues single-outstanding instruction-memory requests, and buffers returned instructions in the IF/ID register plus a one-entry skid. Applies back-pressure from the decode stage and flushes on branch/jump redirects, so the If and Id stages see a clean valid/ready stream.

## Interface
- XLEN, 32, address/PC width
- RESET_PC, 0x0000_0000, first fetch address after reset (bits [1:0] must be 0)
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
- imem_req_valid  out  1  fetch request presented
- imem_req_addr  out  XLEN  fetch address (= pc register)
- imem_req_ready  in  1  memory accepts request this cycle
- imem_resp_valid  in  1  instruction returned (no back-pressure; always consumed)
- imem_resp_data  in  32  instruction word
- id_valid  out  1  IF/ID register holds a live instruction
- id_pc  out  XLEN  PC of id_inst
- id_inst  out  32  instruction to decode
- id_ready  in  1  decode accepts; id fire = id_valid & id_ready
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  XLEN  new fetch address; bits [1:0] forced to 0
- fetch_count  out  32  number of id fires since reset, wraps at 2^32

## Operation
- Registers: state, pc, req_pc, kill, ifid {valid, pc, inst}, skid {valid, pc, inst}, fetch_count.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: entered only by reset; next cycle → REQ.
- REQ: imem_req_valid=1, addr=pc. On imem_req_ready: req_pc←pc, pc←pc+4 (mod 2^XLEN), → WAIT. imem_resp_valid ignored.
- WAIT: imem_req_valid=0. On imem_resp_valid:
  - kill=1: discard, clear kill, → REQ.
  - else if ifid empty or id fire this cycle: ifid←{1, req_pc, data}, → REQ.
  - else: skid←{1, req_pc, data}, → HOLD.
- HOLD: no requests. On id fire: ifid←skid, skid.valid←0, → REQ.
- id fire with no refill: ifid.valid←0; fetch_count+1 on every id fire.
- Redirect (any state except IDLE, highest priority): pc←redirect_pc&~3; ifid.valid←0; skid.valid←0.
  - REQ without acceptance, HOLD, or WAIT with resp this cycle → REQ, kill←0.
  - WAIT without resp, or REQ with acceptance same cycle → WAIT, kill←1.
  - An id fire in the redirect cycle still counts in fetch_count.
- Redirect in IDLE is ignored.
- At most one request outstanding; the skid guarantees no response is ever lost.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, imem_req_valid=0, imem_req_addr=RESET_PC, id_valid=0, id_pc=0, id_inst=0, fetch_count=0, kill=0, skid.valid=0.
- imem_req_valid/addr are decoded from registered state/pc; no combinational path from any input.
- First request: cycle 1 after reset release (cycle 0 = IDLE).
- Request accepted in cycle t → response accepted no earlier than t+1.
- Response in cycle n → id_valid=1 from cycle n+1; next request issued in cycle n+1.
- Peak throughput: 1 instruction per 2 cycles (1-cycle memory).
- id_valid/id_pc/id_inst are held stable while id_valid & !id_ready.
- Redirect in cycle r → id_valid=0 at r+1; first request to the new PC at r+1 (REQ) or after the killed response is absorbed (WAIT).
- Reset asserted mid-operation: all registers clear asynchronously; any in-flight response after release is ignored (state IDLE/REQ).

## Test plan
- Stream: ready=1, 1-cycle memory, id_ready=1 → id_pc 0x0,0x4,0x8,0xC on every other cycle from cycle 3; fetch_count=4 after 4th fire.
- Decode stall: hold id_ready=0 for 6 cycles → ifid holds 0x0, skid takes 0x4, state HOLD, no requests; release → 0x0 then 0x4 on consecutive fires, next request addr 0x8.
- Redirect in WAIT: redirect_pc=0x1002 while a request to 0x8 is outstanding → response for 0x8 dropped, next request addr 0x1000, id_pc never shows 0x8.
- Redirect coincident with response: redirect_pc=0x200 in the response cycle → response dropped, next request addr 0x200 one cycle later, kill=0.
- Wrap: RESET_PC=0xFFFF_FFF8 → delivered id_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Reset mid-WAIT: assert reset with a request outstanding → outputs return to reset values immediately; after release, first request to RESET_PC in cycle 1; stale response ignored.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF->ID fetch sequencer.
//
// Owns the next-fetch PC and keeps at most one instruction-memory request in
// flight. Returned instructions land in the IF/ID register, or in a one-entry
// skid buffer when decode is stalled, so no response is ever dropped.
// Branch/jump redirects flush both buffers and restart fetch at the new PC. A
// response that is still in flight when a redirect arrives is marked stale
// with the kill flag and discarded when it returns.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   imem_req_valid_o    request presented (decoded from registered state)
//   imem_req_addr_o     request address (the pc register)
//   imem_req_ready_i    memory accepts the request this cycle
//   imem_resp_valid_i   instruction returned (always consumed)
//   imem_resp_data_i    instruction word
//   id_valid_o          IF/ID register holds a live instruction
//   id_pc_o, id_inst_o  PC and instruction word of the IF/ID entry
//   id_ready_i          decode accepts the IF/ID entry
//   redirect_valid_i    flush and restart fetch
//   redirect_pc_i       restart address (bits [1:0] ignored)
//   fetch_count_o       number of decode handshakes since reset (wraps)

module fetch_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_valid_o,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_req_ready_i,
  input  logic            imem_resp_valid_i,
  input  logic [31:0]     imem_resp_data_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [31:0]     id_inst_o,
  input  logic            id_ready_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [31:0]     fetch_count_o
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StHold
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            kill_q, kill_d;

  logic            ifid_valid_q, ifid_valid_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]     ifid_inst_q, ifid_inst_d;

  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]     skid_inst_q, skid_inst_d;

  logic [31:0]     fetch_count_q, fetch_count_d;

  logic            id_fire;
  logic            redirect_take;

  assign id_fire       = ifid_valid_q & id_ready_i;
  // IDLE only exists for the single cycle after reset; redirects there are dropped.
  assign redirect_take = redirect_valid_i & (state_q != StIdle);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    kill_d        = kill_q;
    ifid_valid_d  = ifid_valid_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_inst_d   = ifid_inst_q;
    skid_valid_d  = skid_valid_q;
    skid_pc_d     = skid_pc_q;
    skid_inst_d   = skid_inst_q;
    fetch_count_d = fetch_count_q;

    // A handshake empties IF/ID unless a refill below overrides it.
    if (id_fire) begin
      ifid_valid_d  = 1'b0;
      fetch_count_d = fetch_count_q + 32'd1;
    end

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
      end
      StReq: begin
        if (imem_req_ready_i) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          state_d  = StWait;
        end
      end
      StWait: begin
        if (imem_resp_valid_i) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = StReq;
          end else if (!ifid_valid_q || id_fire) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = req_pc_q;
            ifid_inst_d  = imem_resp_data_i;
            state_d      = StReq;
          end else begin
            // Decode is stalled on a full IF/ID: park the word in the skid.
            skid_valid_d = 1'b1;
            skid_pc_d    = req_pc_q;
            skid_inst_d  = imem_resp_data_i;
            state_d      = StHold;
          end
        end
      end
      StHold: begin
        if (id_fire) begin
          ifid_valid_d = 1'b1;
          ifid_pc_d    = skid_pc_q;
          ifid_inst_d  = skid_inst_q;
          skid_valid_d = 1'b0;
          state_d      = StReq;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Redirect overrides everything above except the fetch counter.
    if (redirect_take) begin
      pc_d         = redirect_pc_i & ~(XLEN'(3));
      ifid_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      // If a response is (or is about to be) in flight, wait for it and drop it.
      if (((state_q == StWait) && !imem_resp_valid_i) ||
          ((state_q == StReq) && imem_req_ready_i)) begin
        state_d = StWait;
        kill_d  = 1'b1;
      end else begin
        state_d = StReq;
        kill_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      req_pc_q      <= '0;
      kill_q        <= 1'b0;
      ifid_valid_q  <= 1'b0;
      ifid_pc_q     <= '0;
      ifid_inst_q   <= '0;
      skid_valid_q  <= 1'b0;
      skid_pc_q     <= '0;
      skid_inst_q   <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      kill_q        <= kill_d;
      ifid_valid_q  <= ifid_valid_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_inst_q   <= ifid_inst_d;
      skid_valid_q  <= skid_valid_d;
      skid_pc_q     <= skid_pc_d;
      skid_inst_q   <= skid_inst_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_req_valid_o = (state_q == StReq);
  assign imem_req_addr_o  = pc_q;
  assign id_valid_o       = ifid_valid_q;
  assign id_pc_o          = ifid_pc_q;
  assign id_inst_o        = ifid_inst_q;
  assign fetch_count_o    = fetch_count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl. Reference model: the delivered stream must be the
// PCs counting up by 4 from the reset or redirect target, each carrying the
// word the memory model returns for that address, with fetch_count equal to
// the number of decode handshakes seen so far.

module tb_fetch_ctrl;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam logic [31:0] WrapPc  = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready = 1'b0;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = '0;
  logic [31:0] fcount;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_resp_valid;
  logic [31:0] w_resp_data;
  logic        w_id_valid;
  logic [31:0] w_id_pc;
  logic [31:0] w_id_inst;
  logic [31:0] w_fcount;

  int          n_vec = 0;
  int          n_err = 0;

  // Reference model state
  int          cyc;
  int          lat = 1;
  logic [31:0] exp_pc;
  int unsigned fires;
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          stale = 0;
  logic        hold_prev;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  fetch_ctrl #(
    .XLEN     (32),
    .RESET_PC (ResetPc)
  ) u_dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .imem_req_valid_o  (req_valid),
    .imem_req_addr_o   (req_addr),
    .imem_req_ready_i  (req_ready),
    .imem_resp_valid_i (resp_valid),
    .imem_resp_data_i  (resp_data),
    .id_valid_o        (id_valid),
    .id_pc_o           (id_pc),
    .id_inst_o         (id_inst),
    .id_ready_i        (id_ready),
    .redirect_valid_i  (redir),
    .redirect_pc_i     (redir_pc),
    .fetch_count_o     (fcount)
  );

  fetch_ctrl #(
    .XLEN     (32),
    .RESET_PC (WrapPc)
  ) u_wrap (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .imem_req_valid_o  (w_req_valid),
    .imem_req_addr_o   (w_req_addr),
    .imem_req_ready_i  (1'b1),
    .imem_resp_valid_i (w_resp_valid),
    .imem_resp_data_i  (w_resp_data),
    .id_valid_o        (w_id_valid),
    .id_pc_o           (w_id_pc),
    .id_inst_o         (w_id_inst),
    .id_ready_i        (1'b1),
    .redirect_valid_i  (1'b0),
    .redirect_pc_i     (32'h0),
    .fetch_count_o     (w_fcount)
  );

  // One-cycle memory for the wrap instance: always ready, answers next cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_resp_valid <= 1'b0;
      w_resp_data  <= '0;
    end else begin
      w_resp_valid <= w_req_valid;
      w_resp_data  <= inst_of(w_req_addr);
    end
  end

  task automatic model_reset();
    exp_pc    = ResetPc;
    fires     = 0;
    pend      = 1'b0;
    pend_addr = '0;
    pend_cnt  = 0;
    hold_prev = 1'b0;
    cyc       = 0;
  endtask

  // Called right after a negedge: drive one cycle of inputs, check, advance.
  task automatic tick(input logic rdy, input logic idr, input logic rd, input logic [31:0] rpc);
    logic resp_now;
    req_ready = rdy;
    id_ready  = idr;
    redir     = rd;
    redir_pc  = rpc;
    resp_now  = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) resp_now = 1'b1;
      else pend_cnt--;
    end
    if (resp_now) begin
      resp_valid = 1'b1;
      resp_data  = inst_of(pend_addr);
    end else if (stale > 0) begin
      resp_valid = 1'b1;
      resp_data  = $urandom;
      stale--;
    end else begin
      resp_valid = 1'b0;
      resp_data  = $urandom;
    end
    #1;
    n_vec++;
    if (fcount !== fires) begin
      n_err++;
      $display("FAIL fetch_count cyc=%0d: got %0d want %0d", cyc, fcount, fires);
    end
    if (hold_prev) begin
      n_vec++;
      if (id_valid !== 1'b1 || id_pc !== hold_pc || id_inst !== hold_inst) begin
        n_err++;
        $display("FAIL stall_hold cyc=%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                 cyc, id_valid, id_pc, id_inst, hold_pc, hold_inst);
      end
    end
    if (req_valid === 1'b1) begin
      n_vec++;
      if (pend || req_addr[1:0] !== 2'b00) begin
        n_err++;
        $display("FAIL single_outstanding cyc=%0d: got req addr=%h with pending=%b, want none",
                 cyc, req_addr, pend);
      end
    end
    if (id_valid === 1'b1 && idr) begin
      n_vec++;
      if (id_pc !== exp_pc || id_inst !== inst_of(exp_pc)) begin
        n_err++;
        $display("FAIL deliver cyc=%0d: got pc=%h inst=%h want pc=%h inst=%h",
                 cyc, id_pc, id_inst, exp_pc, inst_of(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
      fires++;
    end
    hold_prev = (id_valid === 1'b1) && !idr && !rd;
    hold_pc   = id_pc;
    hold_inst = id_inst;
    if (resp_now) pend = 1'b0;
    if (req_valid === 1'b1 && rdy) begin
      pend      = 1'b1;
      pend_addr = req_addr;
      pend_cnt  = lat - 1;
    end
    if (rd && cyc > 0) exp_pc = rpc & ~32'd3;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    stale = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (req_valid !== 1'b0 || req_addr !== ResetPc) begin
      n_err++;
      $display("FAIL reset_req: got v=%b addr=%h want v=0 addr=%h", req_valid, req_addr, ResetPc);
    end
    n_vec++;
    if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0) begin
      n_err++;
      $display("FAIL reset_id: got v=%b pc=%h inst=%h want 0/0/0", id_valid, id_pc, id_inst);
    end
    n_vec++;
    if (fcount !== 32'h0) begin
      n_err++;
      $display("FAIL reset_count: got %0d want 0", fcount);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    lat = 1;
    // Cycle 0 is IDLE; a redirect here must be ignored.
    n_vec++;
    if (req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_cycle0: got req_valid=%b want 0", req_valid);
    end
    tick(1'b1, 1'b1, 1'b1, 32'h0000_4000);
    n_vec++;
    if (req_valid !== 1'b1 || req_addr !== ResetPc) begin
      n_err++;
      $display("FAIL first_req: got v=%b addr=%h want v=1 addr=%h", req_valid, req_addr, ResetPc);
    end
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    n_vec++;
    if (req_valid !== 1'b1 || req_addr !== ResetPc) begin
      n_err++;
      $display("FAIL req_hold: got v=%b addr=%h want v=1 addr=%h", req_valid, req_addr, ResetPc);
    end
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1;
    for (int c = 0; c <= 10; c++) begin
      n_vec++;
      if (req_valid !== (c % 2 == 1)) begin
        n_err++;
        $display("FAIL stream_req c=%0d: got %b want %b", c, req_valid, (c % 2 == 1));
      end
      n_vec++;
      if (id_valid !== (c >= 3 && c % 2 == 1) ||
          (c >= 3 && c % 2 == 1 && id_pc !== 32'((c - 3) / 2 * 4))) begin
        n_err++;
        $display("FAIL stream_id c=%0d: got v=%b pc=%h want v=%b pc=%h", c, id_valid, id_pc,
                 (c >= 3 && c % 2 == 1), 32'((c - 3) / 2 * 4));
      end
      if (c == 10) begin
        n_vec++;
        if (fcount !== 32'd4) begin
          n_err++;
          $display("FAIL stream_count: got %0d want 4", fcount);
        end
      end
      tick(1'b1, 1'b1, 1'b0, 32'h0);
    end
  endtask

  task automatic test_stall();
    do_reset();
    lat = 1;
    for (int c = 0; c <= 12; c++) begin
      if (c >= 4 && c <= 9) begin
        n_vec++;
        if (req_valid !== 1'b0) begin
          n_err++;
          $display("FAIL stall_noreq c=%0d: got req_valid=%b want 0", c, req_valid);
        end
      end
      if (c >= 3 && c <= 9) begin
        n_vec++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
          n_err++;
          $display("FAIL stall_ifid c=%0d: got v=%b pc=%h want v=1 pc=0", c, id_valid, id_pc);
        end
      end
      if (c == 10) begin
        n_vec++;
        if (id_valid !== 1'b1 || id_pc !== 32'h4 || req_valid !== 1'b1 || req_addr !== 32'h8) begin
          n_err++;
          $display("FAIL stall_release: got v=%b pc=%h req=%b addr=%h want 1/4/1/8",
                   id_valid, id_pc, req_valid, req_addr);
        end
      end
      tick(1'b1, !(c >= 3 && c <= 8), 1'b0, 32'h0);
    end
  endtask

  task automatic test_redirect_wait();
    logic found;
    do_reset();
    lat = 2;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (req_valid === 1'b1 && req_addr === 32'h8) begin
        found = 1'b1;
        break;
      end
      tick(1'b1, 1'b1, 1'b0, 32'h0);
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL rw_find: got no request to 8 want one within 40 cycles");
    end
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b1, 32'h0000_1002);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick(1'b1, 1'b1, 1'b0, 32'h0);
    end
    n_vec++;
    if (!found || req_addr !== 32'h0000_1000) begin
      n_err++;
      $display("FAIL rw_newreq: got found=%b addr=%h want addr=00001000", found, req_addr);
    end
    for (int i = 0; i < 12; i++) begin
      if (id_valid === 1'b1 && id_pc === 32'h8) begin
        n_vec++;
        n_err++;
        $display("FAIL rw_killed: got id_pc=%h want never 00000008", id_pc);
      end
      tick(1'b1, 1'b1, 1'b0, 32'h0);
    end
  endtask

  task automatic test_redirect_resp();
    logic found;
    do_reset();
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (req_valid === 1'b1 && req_addr === 32'hC) begin
        found = 1'b1;
        break;
      end
      tick(1'b1, 1'b1, 1'b0, 32'h0);
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL rr_find: got no request to C want one within 40 cycles");
    end
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    n_vec++;
    if (req_valid !== 1'b1 || req_addr !== 32'h200 || id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rr_newreq: got req=%b addr=%h idv=%b want 1/00000200/0",
               req_valid, req_addr, id_valid);
    end
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    n_vec++;
    if (id_valid !== 1'b1 || id_pc !== 32'h200) begin
      n_err++;
      $display("FAIL rr_nokill: got v=%b pc=%h want v=1 pc=00000200", id_valid, id_pc);
    end
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_wrap();
    logic [31:0] want [3];
    int          got;
    want[0] = 32'hFFFF_FFF8;
    want[1] = 32'hFFFF_FFFC;
    want[2] = 32'h0000_0000;
    do_reset();
    lat = 1;
    got = 0;
    for (int i = 0; i < 30 && got < 3; i++) begin
      if (w_id_valid === 1'b1) begin
        n_vec++;
        if (w_id_pc !== want[got] || w_id_inst !== inst_of(want[got])) begin
          n_err++;
          $display("FAIL wrap_%0d: got pc=%h inst=%h want pc=%h inst=%h", got, w_id_pc,
                   w_id_inst, want[got], inst_of(want[got]));
        end
        got++;
      end
      tick(1'b1, 1'b1, 1'b0, 32'h0);
    end
    n_vec++;
    if (got != 3) begin
      n_err++;
      $display("FAIL wrap_count: got %0d deliveries want 3", got);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    lat = 3;
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (req_valid !== 1'b0 || req_addr !== ResetPc || id_valid !== 1'b0 || id_pc !== 32'h0 ||
        id_inst !== 32'h0 || fcount !== 32'h0) begin
      n_err++;
      $display("FAIL midreset_async: got req=%b addr=%h idv=%b pc=%h inst=%h cnt=%0d want reset",
               req_valid, req_addr, id_valid, id_pc, id_inst, fcount);
    end
    model_reset();
    stale = 2;
    lat = 1;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    n_vec++;
    if (req_valid !== 1'b1 || req_addr !== ResetPc) begin
      n_err++;
      $display("FAIL midreset_first: got v=%b addr=%h want v=1 addr=%h", req_valid, req_addr,
               ResetPc);
    end
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
    n_vec++;
    if (fires == 0) begin
      n_err++;
      $display("FAIL midreset_resume: got 0 deliveries want >0");
    end
  endtask

  task automatic test_random();
    logic        rdy;
    logic        idr;
    logic        rd;
    logic [31:0] rpc;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) lat = int'($urandom_range(1, 3));
      rdy = ($urandom % 4) != 0;
      idr = ($urandom % 3) != 0;
      rd  = (cyc > 0) && (($urandom % 25) == 0);
      rpc = $urandom;
      tick(rdy, idr, rd, rpc);
    end
    n_vec++;
    if (fires < 100) begin
      n_err++;
      $display("FAIL random_progress: got %0d deliveries want >=100", fires);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_resp();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
